// File: rtl/remote_comm_n_if.sv
// Command/UART handshake bundle for remote_comm_n.
// master: command source plus UART model; slave: the remote_comm_n block.
interface remote_comm_n_if #(
   parameter int unsigned NBYTES = 2
) ();
   logic [8*NBYTES-1:0] cmd;
   logic                send_cmd;
   logic                cmd_sent;
   logic                err;
   logic                busy;
   logic                trmt;
   logic [7:0]          tx_data;
   logic                tx_done;
   logic                rx_rdy;
   logic [7:0]          rx_data;
   logic                clr_rx_rdy;

   modport master (
      output cmd, send_cmd, tx_done, rx_rdy, rx_data,
      input  cmd_sent, err, busy, trmt, tx_data, clr_rx_rdy
   );

   modport slave (
      input  cmd, send_cmd, tx_done, rx_rdy, rx_data,
      output cmd_sent, err, busy, trmt, tx_data, clr_rx_rdy
   );
endinterface

// File: rtl/remote_comm_n.sv
// Sends an NBYTES command frame (MS byte first) over a UART and waits for an
// ACK byte, resending the whole frame on timeout up to MAX_RETRY times.
module remote_comm_n #(
   parameter int unsigned NBYTES      = 2,
   parameter logic [7:0]  ACK_BYTE    = 8'hA5,
   parameter int unsigned TIMEOUT_CYC = 1_000_000,
   parameter int unsigned MAX_RETRY   = 2
) (
   input logic            clk,
   input logic            rst_n,
   remote_comm_n_if.slave bus
);

   localparam int unsigned IdxW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam int unsigned TimerW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {StIdle, StSend, StWaitTx, StWaitAck} state_e;

   state_e              state_q;
   logic [8*NBYTES-1:0] shadow_q;
   logic [IdxW-1:0]     idx_q;
   logic [3:0]          retry_q;
   logic [TimerW-1:0]   timer_q;
   logic                cmd_sent_q;
   logic                err_q;
   logic                trmt_q;
   logic                clr_rx_rdy_q;
   logic [7:0]          tx_data_q;

   logic rx_valid;
   logic ack_hit;
   logic timeout_hit;

   // rx_rdy is still high in the cycle our clear strobe is out; don't consume it twice.
   assign rx_valid    = bus.rx_rdy && !clr_rx_rdy_q;
   assign ack_hit     = rx_valid && (bus.rx_data == ACK_BYTE);
   assign timeout_hit = (timer_q == TimerW'(TIMEOUT_CYC - 1));

   // Frame sequencer with registered strobes and sticky status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         shadow_q     <= '0;
         idx_q        <= '0;
         retry_q      <= '0;
         timer_q      <= '0;
         cmd_sent_q   <= 1'b0;
         err_q        <= 1'b0;
         trmt_q       <= 1'b0;
         clr_rx_rdy_q <= 1'b0;
         tx_data_q    <= '0;
      end else begin
         trmt_q       <= 1'b0;
         clr_rx_rdy_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (bus.send_cmd) begin
                  shadow_q     <= bus.cmd;
                  idx_q        <= IdxW'(NBYTES - 1);
                  retry_q      <= '0;
                  cmd_sent_q   <= 1'b0;
                  err_q        <= 1'b0;
                  clr_rx_rdy_q <= 1'b1;  // flush any stale received byte
                  state_q      <= StSend;
               end
            end
            StSend: begin
               trmt_q    <= 1'b1;
               tx_data_q <= shadow_q[{idx_q, 3'b000} +: 8];
               state_q   <= StWaitTx;
            end
            StWaitTx: begin
               if (bus.tx_done) begin
                  if (idx_q != '0) begin
                     idx_q   <= idx_q - 1'b1;
                     state_q <= StSend;
                  end else begin
                     timer_q <= '0;
                     state_q <= StWaitAck;
                  end
               end
            end
            StWaitAck: begin
               timer_q <= timer_q + 1'b1;
               if (rx_valid) begin
                  clr_rx_rdy_q <= 1'b1;
               end
               // ACK wins over a coincident timeout.
               if (ack_hit) begin
                  cmd_sent_q <= 1'b1;
                  state_q    <= StIdle;
               end else if (timeout_hit) begin
                  if (retry_q < 4'(MAX_RETRY)) begin
                     retry_q <= retry_q + 1'b1;
                     idx_q   <= IdxW'(NBYTES - 1);
                     state_q <= StSend;
                  end else begin
                     err_q   <= 1'b1;
                     state_q <= StIdle;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.cmd_sent   = cmd_sent_q;
   assign bus.err        = err_q;
   assign bus.busy       = (state_q != StIdle);
   assign bus.trmt       = trmt_q;
   assign bus.tx_data    = tx_data_q;
   assign bus.clr_rx_rdy = clr_rx_rdy_q;

endmodule

// File: tb/tb_remote_comm_n.sv
// Randomized self-checking bench for remote_comm_n: UART responders plus a
// frame-level reference model (expected bytes, attempts, flags, clear strobes).
module tb_remote_comm_n;

   localparam int NB2 = 2;
   localparam int TO2 = 20;
   localparam int MR2 = 2;
   localparam int NB4 = 4;
   localparam int TO4 = 30;

   logic clk;
   logic rst_n;

   remote_comm_n_if #(.NBYTES(NB2)) bus2 ();
   remote_comm_n_if #(.NBYTES(NB4)) bus4 ();

   remote_comm_n #(
      .NBYTES(NB2), .ACK_BYTE(8'hA5), .TIMEOUT_CYC(TO2), .MAX_RETRY(MR2)
   ) dut2 (
      .clk(clk), .rst_n(rst_n), .bus(bus2)
   );

   remote_comm_n #(
      .NBYTES(NB4), .ACK_BYTE(8'hA5), .TIMEOUT_CYC(TO4), .MAX_RETRY(0)
   ) dut4 (
      .clk(clk), .rst_n(rst_n), .bus(bus4)
   );

   int         n_checks = 0;
   int         n_errors = 0;
   int         cyc = 0;
   int         rst_cnt = 0;
   int         clr_cnt2 = 0;
   int         done2 = 0;
   int         done4 = 0;
   int         trmt4_cnt = 0;
   int         last_done_edge2 = 0;
   int         err_edge2 = 0;
   logic       resp2_busy = 1'b0;
   logic [7:0] txq2[$];
   logic [7:0] txq4[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference: byte k of a (possibly repeated) frame, MS byte first.
   function automatic logic [7:0] exp_byte(input logic [31:0] c, input int nb, input int k);
      int pos;
      pos = nb - 1 - (k % nb);
      return 8'((c >> (8 * pos)) & 32'hFF);
   endfunction

   // One cycle step; the UART model drops rx_rdy when the block clears it.
   task automatic tick();
      @(negedge clk);
      if (bus2.clr_rx_rdy) begin
         bus2.rx_rdy = 1'b0;
         clr_cnt2++;
      end
      if (bus4.clr_rx_rdy) bus4.rx_rdy = 1'b0;
   endtask

   // UART transmitter model for dut2: random completion latency.
   initial begin
      logic [7:0] b;
      int         lat;
      int         rc;
      bus2.tx_done = 1'b0;
      forever begin
         @(negedge clk);
         if (bus2.trmt && rst_n) begin
            b  = bus2.tx_data;
            rc = rst_cnt;
            txq2.push_back(b);
            resp2_busy = 1'b1;
            lat = $urandom_range(1, 12);
            repeat (lat) @(negedge clk);
            if (rst_n && rc == rst_cnt) check("tx_stable", bus2.tx_data, b);
            bus2.tx_done = 1'b1;
            done2++;
            last_done_edge2 = cyc + 1;
            @(negedge clk);
            bus2.tx_done = 1'b0;
            resp2_busy = 1'b0;
         end
      end
   end

   // UART transmitter model for dut4: fixed latency.
   initial begin
      bus4.tx_done = 1'b0;
      forever begin
         @(negedge clk);
         if (bus4.trmt && rst_n) begin
            txq4.push_back(bus4.tx_data);
            repeat (3) @(negedge clk);
            bus4.tx_done = 1'b1;
            done4++;
            @(negedge clk);
            bus4.tx_done = 1'b0;
         end
      end
   end

   // Cycle count of trmt high on dut4 (one per byte if strobes are single-cycle).
   initial begin
      forever begin
         @(negedge clk);
         if (bus4.trmt) trmt4_cnt++;
      end
   end

   // Records the clock edge on which dut2 raises err.
   initial begin
      logic prev;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (bus2.err && !prev) err_edge2 = cyc;
         prev = bus2.err;
      end
   end

   task automatic wait_done2(input int target);
      int n;
      n = 0;
      while (done2 < target && n < 1000) begin
         tick();
         n++;
      end
      check("done_cnt", done2, target);
   endtask

   task automatic wait_idle2();
      int n;
      n = 0;
      while (bus2.busy && n < 1000) begin
         tick();
         n++;
      end
      check("idle", bus2.busy, 1'b0);
   endtask

   task automatic inject2(input logic [7:0] b);
      bus2.rx_data = b;
      bus2.rx_rdy  = 1'b1;
   endtask

   // mode 0: ACK; 1: junk 8'h55 then ACK; 2: no ACK; 3: ACK during first resend.
   task automatic run_txn(input logic [15:0] c, input int mode, input bit poke, input bit stale);
      int base_tx, base_done, base_clr, attempts, rx_n, n;
      base_tx   = txq2.size();
      base_done = done2;
      base_clr  = clr_cnt2;
      attempts  = (mode == 2) ? MR2 + 1 : (mode == 3) ? 2 : 1;
      rx_n      = (mode == 2) ? 0 : (mode == 1) ? 2 : 1;
      if (stale) begin
         inject2(8'hA5);
         tick();
      end
      bus2.cmd      = c;
      bus2.send_cmd = 1'b1;
      tick();
      bus2.send_cmd = 1'b0;
      check("busy_after_send", bus2.busy, 1'b1);
      check("trmt_early", bus2.trmt, 1'b0);
      tick();
      check("trmt_latency", bus2.trmt, 1'b1);
      if (poke) begin
         bus2.cmd      = 16'hFFFF;
         bus2.send_cmd = 1'b1;
         tick();
         bus2.send_cmd = 1'b0;
      end
      case (mode)
         0: begin
            wait_done2(base_done + NB2);
            repeat ($urandom_range(1, 8)) tick();
            inject2(8'hA5);
         end
         1: begin
            wait_done2(base_done + NB2);
            repeat ($urandom_range(1, 4)) tick();
            inject2(8'h55);
            n = 0;
            while (bus2.rx_rdy && n < 50) begin
               tick();
               n++;
            end
            tick();
            check("no_ack_on_junk", bus2.cmd_sent, 1'b0);
            inject2(8'hA5);
         end
         3: begin
            wait_done2(base_done + 2 * NB2);
            repeat ($urandom_range(1, 8)) tick();
            inject2(8'hA5);
         end
         default: ;
      endcase
      wait_idle2();
      check("frame_bytes", txq2.size() - base_tx, attempts * NB2);
      for (int k = 0; k < attempts * NB2 && base_tx + k < txq2.size(); k++)
         check("tx_byte", txq2[base_tx + k], exp_byte(32'(c), NB2, k));
      check("cmd_sent", bus2.cmd_sent, (mode != 2));
      check("err", bus2.err, (mode == 2));
      check("clr_pulses", clr_cnt2 - base_clr, 1 + rx_n);
      if (mode == 2) check("err_timing", err_edge2 - last_done_edge2, TO2);
      repeat (3) tick();
      check("flags_hold", {bus2.cmd_sent, bus2.err}, {mode != 2, mode == 2});
   endtask

   initial begin
      logic [15:0] c;
      int          mode;
      int          base4, n;
      bit          stale;

      rst_n = 1'b0;
      bus2.cmd = '0;  bus2.send_cmd = 1'b0;  bus2.rx_rdy = 1'b0;  bus2.rx_data = '0;
      bus4.cmd = '0;  bus4.send_cmd = 1'b0;  bus4.rx_rdy = 1'b0;  bus4.rx_data = '0;
      repeat (3) tick();
      check("rst_cmd_sent", bus2.cmd_sent, 1'b0);
      check("rst_err", bus2.err, 1'b0);
      check("rst_busy", bus2.busy, 1'b0);
      check("rst_trmt", bus2.trmt, 1'b0);
      check("rst_clr", bus2.clr_rx_rdy, 1'b0);
      check("rst_tx_data", bus2.tx_data, 8'h00);
      rst_n = 1'b1;
      repeat (2) tick();

      // 16'h12AB with ACK, plus a send_cmd of FFFF while busy that must be ignored.
      run_txn(16'h12AB, 0, 1'b1, 1'b0);
      // Junk byte before the ACK.
      run_txn(16'h12AB, 1, 1'b0, 1'b0);
      // No ACK: three full frames then err; a stale ACK-valued byte must be flushed.
      run_txn(16'h3C5A, 2, 1'b0, 1'b1);

      // Reset between bytes 1 and 2.
      bus2.cmd      = 16'h12AB;
      bus2.send_cmd = 1'b1;
      tick();
      bus2.send_cmd = 1'b0;
      n = done2;
      wait_done2(n + 1);
      tick();
      rst_cnt++;
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", bus2.busy, 1'b0);
      check("mid_rst_trmt", bus2.trmt, 1'b0);
      check("mid_rst_tx_data", bus2.tx_data, 8'h00);
      check("mid_rst_flags", {bus2.cmd_sent, bus2.err, bus2.clr_rx_rdy}, 3'b000);
      n = txq2.size();
      repeat (3) tick();
      rst_n = 1'b1;
      for (int i = 0; i < 15 && resp2_busy; i++) tick();
      repeat (5) tick();
      check("no_trmt_after_rst", txq2.size() - n, 0);
      check("idle_after_rst", bus2.busy, 1'b0);
      run_txn(16'h12AB, 0, 1'b0, 1'b0);

      // Randomized transactions against the frame model.
      for (int i = 0; i < 12; i++) begin
         c     = 16'($urandom);
         mode  = $urandom_range(0, 3);
         stale = (mode == 2) && ($urandom_range(0, 1) == 1);
         run_txn(c, mode, ($urandom_range(0, 3) == 0), stale);
      end

      // Four-byte frame, single attempt.
      base4 = txq4.size();
      trmt4_cnt = 0;
      bus4.cmd      = 32'hDEADBEEF;
      bus4.send_cmd = 1'b1;
      tick();
      bus4.send_cmd = 1'b0;
      n = 0;
      while (done4 < 4 && n < 200) begin
         tick();
         n++;
      end
      check("done4", done4, 4);
      repeat (2) tick();
      bus4.rx_data = 8'hA5;
      bus4.rx_rdy  = 1'b1;
      n = 0;
      while (bus4.busy && n < 200) begin
         tick();
         n++;
      end
      check("idle4", bus4.busy, 1'b0);
      check("bytes4", txq4.size() - base4, 4);
      if (txq4.size() - base4 >= 4) begin
         check("byte4_0", txq4[base4], 8'hDE);
         check("byte4_1", txq4[base4 + 1], 8'hAD);
         check("byte4_2", txq4[base4 + 2], 8'hBE);
         check("byte4_3", txq4[base4 + 3], 8'hEF);
      end
      check("trmt4_pulses", trmt4_cnt, 4);
      check("cmd_sent4", bus4.cmd_sent, 1'b1);
      check("err4_clear", bus4.err, 1'b0);

      // MAX_RETRY=0: first timeout sets err after one frame.
      base4 = txq4.size();
      bus4.cmd      = $urandom;
      bus4.send_cmd = 1'b1;
      tick();
      bus4.send_cmd = 1'b0;
      n = 0;
      while (bus4.busy && n < 300) begin
         tick();
         n++;
      end
      check("idle4_to", bus4.busy, 1'b0);
      check("bytes4_to", txq4.size() - base4, 4);
      check("err4", bus4.err, 1'b1);
      check("cmd_sent4_to", bus4.cmd_sent, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish in time (checks %0d)", n_checks);
      $fatal(1, "watchdog");
   end

endmodule
